stack_cpu_controller: RTL and testbench

- Multicycle control unit for the 8-bit stack processor; sits directly upstream of the datapath muxes (2x8, 3x8, 2x13, 2x2, 2x1) and drives their selects, plus register, stack and memory strobes.
- Fetches 1- or 2-byte instructions from byte-wide memory with a ready handshake, sequences stack and ALU operations, and latches an error on stack underflow/overflow.

---
 rtl/stack_cpu_pkg.sv | 67 ++++++
 rtl/stack_cpu_decode.sv | 72 +++++++
 rtl/stack_cpu_controller.sv | 107 ++++++++++
 tb/tb_stack_cpu_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared types and encodings for the stack-processor control unit.
// The decoder, the state register and the bench all use these encodings.
package stack_cpu_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int OPC_W  = 3;

   typedef enum logic [3:0] {
      S_IF1      = 4'd0,
      S_ID       = 4'd1,
      S_IF2      = 4'd2,
      S_MEM_RD   = 4'd3,
      S_PUSH_M   = 4'd4,
      S_POP_A    = 4'd5,
      S_POP_B    = 4'd6,
      S_ALU_PUSH = 4'd7,
      S_MEM_WR   = 4'd8,
      S_JUMP     = 4'd9,
      S_JZ_CHK   = 4'd10,
      S_ERR      = 4'd11
   } state_e;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_NOT  = 3'b011,
      OP_PUSH = 3'b100,
      OP_POP  = 3'b101,
      OP_JMP  = 3'b110,
      OP_JZ   = 3'b111
   } opcode_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

   localparam logic [1:0] DIN_MDR = 2'b00;
   localparam logic [1:0] DIN_ALU = 2'b01;

   localparam logic ADDR_PC = 1'b0;
   localparam logic ADDR_IR = 1'b1;
   localparam logic PC_INC  = 1'b0;
   localparam logic PC_IR   = 1'b1;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       addr_sel;
      logic       pc_src;
      logic       pc_write;
      logic       ir1_write;
      logic       ir2_write;
      logic       mdr_write;
      logic       a_write;
      logic       b_write;
      logic       stack_push;
      logic       stack_pop;
      logic [1:0] stack_din_sel;
      logic [1:0] alu_op;
      logic       err;
      logic       busy;
   } ctrl_t;

endpackage

// File: rtl/stack_cpu_decode.sv
// Combinational control-word decoder: current state, ALU selector and
// handshake/stack flags in, every datapath select and strobe out.
module stack_cpu_decode
   import stack_cpu_pkg::*;
(
   input  state_e     state_i,
   input  logic [1:0] alu_op_i,
   input  logic       mem_ready_i,
   input  logic       tos_zero_i,
   input  logic       stack_empty_i,
   input  logic       stack_full_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o      = '0;
      ctrl_o.busy = (state_i != S_IF1);
      unique case (state_i)
         S_IF1, S_IF2: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.addr_sel = ADDR_PC;
            if (mem_ready_i) begin
               ctrl_o.ir1_write = (state_i == S_IF1);
               ctrl_o.ir2_write = (state_i == S_IF2);
               ctrl_o.pc_write  = 1'b1;
               ctrl_o.pc_src    = PC_INC;
            end
         end
         S_MEM_RD: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.addr_sel  = ADDR_IR;
            ctrl_o.mdr_write = mem_ready_i;
         end
         S_PUSH_M: begin
            // A push into a full stack faults instead of pushing.
            ctrl_o.err           = stack_full_i;
            ctrl_o.stack_push    = ~stack_full_i;
            ctrl_o.stack_din_sel = DIN_MDR;
         end
         S_POP_A: begin
            ctrl_o.err       = stack_empty_i;
            ctrl_o.stack_pop = ~stack_empty_i;
            ctrl_o.a_write   = ~stack_empty_i;
         end
         S_POP_B: begin
            ctrl_o.err       = stack_empty_i;
            ctrl_o.stack_pop = ~stack_empty_i;
            ctrl_o.b_write   = ~stack_empty_i;
         end
         S_ALU_PUSH: begin
            ctrl_o.stack_push    = 1'b1;
            ctrl_o.stack_din_sel = DIN_ALU;
            ctrl_o.alu_op        = alu_op_i;
         end
         S_MEM_WR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.addr_sel  = ADDR_IR;
         end
         S_JUMP: begin
            ctrl_o.pc_write = 1'b1;
            ctrl_o.pc_src   = PC_IR;
         end
         S_JZ_CHK: begin
            ctrl_o.pc_write = tos_zero_i;
            ctrl_o.pc_src   = PC_IR;
         end
         S_ERR: ctrl_o.err = 1'b1;
         default: ctrl_o.busy = 1'b1;
      endcase
   end

endmodule

// File: rtl/stack_cpu_controller.sv
// Multicycle control unit for the 8-bit stack processor: state register,
// next-state sequencing and the decoded control outputs.
module stack_cpu_controller
   import stack_cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic             mem_ready,
   input  logic             tos_zero,
   input  logic             stack_empty,
   input  logic             stack_full,
   output logic             mem_read,
   output logic             mem_write,
   output logic             addr_sel,
   output logic             pc_src,
   output logic             pc_write,
   output logic             ir1_write,
   output logic             ir2_write,
   output logic             mdr_write,
   output logic             a_write,
   output logic             b_write,
   output logic             stack_push,
   output logic             stack_pop,
   output logic [1:0]       stack_din_sel,
   output logic [1:0]       alu_op,
   output logic             err,
   output logic             busy
);

   state_e  state_q, state_d;
   opcode_e op;
   ctrl_t   ctrl, ctrl_out;

   assign op = opcode_e'(opcode);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IF1:    if (mem_ready) state_d = S_ID;
         S_ID:     state_d = op[2] ? S_IF2 : S_POP_A;
         S_IF2: begin
            if (mem_ready) begin
               unique case (op)
                  OP_PUSH: state_d = S_MEM_RD;
                  OP_POP:  state_d = S_POP_A;
                  OP_JMP:  state_d = S_JUMP;
                  OP_JZ:   state_d = S_JZ_CHK;
                  default: state_d = S_POP_A;
               endcase
            end
         end
         S_MEM_RD: if (mem_ready) state_d = S_PUSH_M;
         S_PUSH_M: state_d = stack_full ? S_ERR : S_IF1;
         S_POP_A: begin
            if (stack_empty)       state_d = S_ERR;
            else if (op == OP_POP) state_d = S_MEM_WR;
            else if (op == OP_NOT) state_d = S_ALU_PUSH;
            else                   state_d = S_POP_B;
         end
         S_POP_B:    state_d = stack_empty ? S_ERR : S_ALU_PUSH;
         S_ALU_PUSH: state_d = S_IF1;
         S_MEM_WR:   if (mem_ready) state_d = S_IF1;
         S_JUMP:     state_d = S_IF1;
         S_JZ_CHK:   state_d = S_IF1;
         S_ERR:      state_d = S_ERR;
         default:    state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IF1;
      else        state_q <= state_d;
   end

   stack_cpu_decode u_decode (
      .state_i       (state_q),
      .alu_op_i      (opcode[1:0]),
      .mem_ready_i   (mem_ready),
      .tos_zero_i    (tos_zero),
      .stack_empty_i (stack_empty),
      .stack_full_i  (stack_full),
      .ctrl_o        (ctrl)
   );

   // Gating with rst_n drops every strobe the moment reset asserts,
   // including a memory write that has not yet been acknowledged.
   assign ctrl_out = rst_n ? ctrl : '0;

   assign mem_read      = ctrl_out.mem_read;
   assign mem_write     = ctrl_out.mem_write;
   assign addr_sel      = ctrl_out.addr_sel;
   assign pc_src        = ctrl_out.pc_src;
   assign pc_write      = ctrl_out.pc_write;
   assign ir1_write     = ctrl_out.ir1_write;
   assign ir2_write     = ctrl_out.ir2_write;
   assign mdr_write     = ctrl_out.mdr_write;
   assign a_write       = ctrl_out.a_write;
   assign b_write       = ctrl_out.b_write;
   assign stack_push    = ctrl_out.stack_push;
   assign stack_pop     = ctrl_out.stack_pop;
   assign stack_din_sel = ctrl_out.stack_din_sel;
   assign alu_op        = ctrl_out.alu_op;
   assign err           = ctrl_out.err;
   assign busy          = ctrl_out.busy;

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Directed bench: each cycle's expected control word is queued as the
// stimulus is driven, then popped and compared on the falling edge.
module tb_stack_cpu_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       mem_ready = 1'b0;
   logic       tos_zero = 1'b0;
   logic       stack_empty = 1'b0;
   logic       stack_full = 1'b0;
   logic       mem_read, mem_write, addr_sel, pc_src, pc_write;
   logic       ir1_write, ir2_write, mdr_write, a_write, b_write;
   logic       stack_push, stack_pop, err, busy;
   logic [1:0] stack_din_sel, alu_op;

   stack_cpu_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .tos_zero      (tos_zero),
      .stack_empty   (stack_empty),
      .stack_full    (stack_full),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .addr_sel      (addr_sel),
      .pc_src        (pc_src),
      .pc_write      (pc_write),
      .ir1_write     (ir1_write),
      .ir2_write     (ir2_write),
      .mdr_write     (mdr_write),
      .a_write       (a_write),
      .b_write       (b_write),
      .stack_push    (stack_push),
      .stack_pop     (stack_pop),
      .stack_din_sel (stack_din_sel),
      .alu_op        (alu_op),
      .err           (err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Observed control word, one bit per strobe/select.
   logic [17:0] obs;
   assign obs = {mem_read, mem_write, addr_sel, pc_src, pc_write, ir1_write,
                 ir2_write, mdr_write, a_write, b_write, stack_push, stack_pop,
                 stack_din_sel, alu_op, err, busy};

   localparam logic [17:0] MRD   = 18'h1_0000 << 1;
   localparam logic [17:0] MWR   = 18'h1_0000;
   localparam logic [17:0] ASEL  = 18'h0_8000;
   localparam logic [17:0] PSRC  = 18'h0_4000;
   localparam logic [17:0] PCW   = 18'h0_2000;
   localparam logic [17:0] IR1   = 18'h0_1000;
   localparam logic [17:0] IR2   = 18'h0_0800;
   localparam logic [17:0] MDR   = 18'h0_0400;
   localparam logic [17:0] AW    = 18'h0_0200;
   localparam logic [17:0] BW    = 18'h0_0100;
   localparam logic [17:0] PUSH  = 18'h0_0080;
   localparam logic [17:0] POP   = 18'h0_0040;
   localparam logic [17:0] DALU  = 18'h0_0010;
   localparam logic [17:0] A_SUB = 18'h0_0004;
   localparam logic [17:0] A_NOT = 18'h0_000C;
   localparam logic [17:0] ERRB  = 18'h0_0002;
   localparam logic [17:0] BUSY  = 18'h0_0001;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [17:0] sb[$];

   task automatic check(input string tag);
      logic [17:0] exp_w;
      exp_w = sb.pop_front();
      n_checks++;
      assert (obs === exp_w) else begin
         n_errors++;
         $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp_w);
      end
   endtask

   task automatic cyc(input string tag, input logic [17:0] w);
      sb.push_back(w);
      @(negedge clk);
      check(tag);
      @(posedge clk);
      #1;
   endtask

   // Standard fetch of a 2-byte instruction with memory always ready.
   task automatic fetch2(input string name);
      cyc({name, "_if1"}, MRD | IR1 | PCW);
      cyc({name, "_id"},  BUSY);
      cyc({name, "_if2"}, MRD | IR2 | PCW | BUSY);
   endtask

   initial begin
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc("reset", 18'h0);
      rst_n = 1'b1;

      // ADD, stack depth 2: five cycles ending back at IF1.
      opcode = 3'b000;
      cyc("add_if1",  MRD | IR1 | PCW);
      cyc("add_id",   BUSY);
      cyc("add_popa", POP | AW | BUSY);
      cyc("add_popb", POP | BW | BUSY);
      cyc("add_push", PUSH | DALU | BUSY);
      $display("instr ADD done");

      // PUSH with two wait states in every memory phase: 11 cycles.
      opcode = 3'b100;
      mem_ready = 1'b0;
      cyc("push_if1_w0", MRD);
      cyc("push_if1_w1", MRD);
      mem_ready = 1'b1;
      cyc("push_if1", MRD | IR1 | PCW);
      cyc("push_id",  BUSY);
      mem_ready = 1'b0;
      cyc("push_if2_w0", MRD | BUSY);
      cyc("push_if2_w1", MRD | BUSY);
      mem_ready = 1'b1;
      cyc("push_if2", MRD | IR2 | PCW | BUSY);
      mem_ready = 1'b0;
      cyc("push_rd_w0", MRD | ASEL | BUSY);
      cyc("push_rd_w1", MRD | ASEL | BUSY);
      mem_ready = 1'b1;
      cyc("push_rd",  MRD | ASEL | MDR | BUSY);
      cyc("push_m",   PUSH | BUSY);
      $display("instr PUSH done");

      // JZ taken, JZ not taken, then JMP.
      opcode = 3'b111;
      tos_zero = 1'b1;
      fetch2("jz1");
      cyc("jz1_chk", PCW | PSRC | BUSY);
      $display("instr JZ (taken) done");
      tos_zero = 1'b0;
      fetch2("jz0");
      cyc("jz0_chk", PSRC | BUSY);
      $display("instr JZ (not taken) done");
      opcode = 3'b110;
      fetch2("jmp");
      cyc("jmp_jump", PCW | PSRC | BUSY);
      $display("instr JMP done");

      // SUB selects alu_op 01 on the final push.
      opcode = 3'b001;
      cyc("sub_if1",  MRD | IR1 | PCW);
      cyc("sub_id",   BUSY);
      cyc("sub_popa", POP | AW | BUSY);
      cyc("sub_popb", POP | BW | BUSY);
      cyc("sub_push", PUSH | DALU | A_SUB | BUSY);
      $display("instr SUB done");

      // NOT with depth 1: one pop only, no fault.
      opcode = 3'b011;
      cyc("not_if1",  MRD | IR1 | PCW);
      cyc("not_id",   BUSY);
      cyc("not_popa", POP | AW | BUSY);
      stack_empty = 1'b1;
      cyc("not_push", PUSH | DALU | A_NOT | BUSY);
      cyc("not_next", MRD | IR1 | PCW);
      $display("instr NOT done");

      // POP from an empty stack faults; err sticks until reset.
      opcode = 3'b101;
      cyc("pope_id",  BUSY);
      cyc("pope_if2", MRD | IR2 | PCW | BUSY);
      cyc("pope_popa", ERRB | BUSY);
      stack_empty = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 20; i++) cyc("pope_err_hold", ERRB | BUSY);
      rst_n = 1'b0;
      cyc("pope_reset", 18'h0);
      rst_n = 1'b1;
      $display("instr POP (underflow) done");

      // PUSH into a full stack faults at PUSH_M without pushing.
      opcode = 3'b100;
      fetch2("pushf");
      cyc("pushf_rd", MRD | ASEL | MDR | BUSY);
      stack_full = 1'b1;
      cyc("pushf_m",   ERRB | BUSY);
      stack_full = 1'b0;
      cyc("pushf_err", ERRB | BUSY);
      rst_n = 1'b0;
      cyc("pushf_reset", 18'h0);
      rst_n = 1'b1;
      $display("instr PUSH (overflow) done");

      // POP with reset asserted mid-write while memory is stalled.
      opcode = 3'b101;
      fetch2("popw");
      cyc("popw_popa", POP | AW | BUSY);
      mem_ready = 1'b0;
      cyc("popw_wr", MWR | ASEL | BUSY);
      sb.push_back(MWR | ASEL | BUSY);
      check("popw_wr_hold");
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back(18'h0);
      check("popw_async_drop");
      @(posedge clk);
      #1;
      cyc("popw_reset", 18'h0);
      rst_n = 1'b1;
      cyc("popw_after_if1", MRD);
      $display("instr POP (reset mid-write) done");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
